// File: rtl/multi_core_trap_monitor.sv
// rtl/multi_core_trap_monitor.sv - first-trap / no-progress watchdog report monitor for a multi-core simulation
module multi_core_trap_monitor #(
  parameter int NUM_CORES = 2,
  parameter int XLEN      = 64,
  parameter int CNT_W     = 64,
  parameter int TIMEOUT   = 5000
) (
  input  logic                                                clk,
  input  logic                                                reset_n,
  input  logic [NUM_CORES-1:0]                                trap_valid,
  input  logic [NUM_CORES*32-1:0]                             trap_code,
  input  logic [NUM_CORES*XLEN-1:0]                           trap_pc,
  input  logic [NUM_CORES*3-1:0]                              commit_num,
  output logic                                                report_valid,
  input  logic                                                report_ready,
  output logic [((NUM_CORES > 1) ? $clog2(NUM_CORES) : 1)-1:0] report_core,
  output logic [31:0]                                         report_code,
  output logic [XLEN-1:0]                                     report_pc,
  output logic [CNT_W-1:0]                                    report_cycles,
  output logic [CNT_W-1:0]                                    report_instrs,
  output logic                                                report_timeout,
  output logic                                                done
);

  localparam int CORE_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_REPORT = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t state, next_state;

  logic [CNT_W-1:0]  cycle_cnt, cycle_inc;
  logic [CNT_W-1:0]  instr_cnt  [NUM_CORES];
  logic [CNT_W-1:0]  instr_next [NUM_CORES];
  logic [CNT_W+2:0]  instr_sum;
  logic [IDLE_W-1:0] idle_cnt, idle_inc;
  logic              any_commit, trap_any, idle_fire;
  logic [CORE_W-1:0] sel_core;
  logic [31:0]       sel_code;
  logic [XLEN-1:0]   sel_pc;
  logic [CNT_W-1:0]  sel_instrs;

  // Counter values as they will stand after this cycle; the report latches these.
  always_comb begin
    any_commit = |commit_num;
    cycle_inc  = (&cycle_cnt) ? cycle_cnt : cycle_cnt + CNT_W'(1);
    idle_inc   = idle_cnt + IDLE_W'(1);
    idle_fire  = !any_commit && (idle_inc >= IDLE_W'(TIMEOUT));
    instr_sum  = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      instr_sum     = (CNT_W+3)'(instr_cnt[i]) + (CNT_W+3)'(commit_num[3*i +: 3]);
      instr_next[i] = (|instr_sum[CNT_W+2:CNT_W]) ? {CNT_W{1'b1}} : instr_sum[CNT_W-1:0];
    end
  end

  // Walk from the top index down so the lowest asserting core wins.
  always_comb begin
    trap_any   = |trap_valid;
    sel_core   = '0;
    sel_code   = '0;
    sel_pc     = '0;
    sel_instrs = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (trap_valid[i]) begin
        sel_core   = CORE_W'(i);
        sel_code   = trap_code[32*i +: 32];
        sel_pc     = trap_pc[XLEN*i +: XLEN];
        sel_instrs = instr_next[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_RUN;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_RUN:    if (trap_any || idle_fire) next_state = S_REPORT;
      S_REPORT: if (report_ready) next_state = S_DONE;
      S_DONE:   next_state = S_DONE;
      default:  next_state = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cycle_cnt      <= '0;
      idle_cnt       <= '0;
      for (int i = 0; i < NUM_CORES; i++) begin
        instr_cnt[i] <= '0;
      end
      report_core    <= '0;
      report_code    <= '0;
      report_pc      <= '0;
      report_cycles  <= '0;
      report_instrs  <= '0;
      report_timeout <= 1'b0;
    end else if (state == S_RUN) begin
      cycle_cnt <= cycle_inc;
      idle_cnt  <= any_commit ? '0 : idle_inc;
      for (int i = 0; i < NUM_CORES; i++) begin
        instr_cnt[i] <= instr_next[i];
      end
      if (trap_any) begin
        report_core    <= sel_core;
        report_code    <= sel_code;
        report_pc      <= sel_pc;
        report_cycles  <= cycle_inc;
        report_instrs  <= sel_instrs;
        report_timeout <= 1'b0;
      end else if (idle_fire) begin
        report_core    <= '0;
        report_code    <= 32'hFFFF_FFFF;
        report_pc      <= '0;
        report_cycles  <= cycle_inc;
        report_instrs  <= instr_next[0];
        report_timeout <= 1'b1;
      end
    end
  end

  // Decoded straight from the state register, so reset drops them without a clock.
  assign report_valid = (state == S_REPORT);
  assign done         = (state == S_DONE);

endmodule
